// File: rtl/lsu_pkg.sv
// Shared encodings, state type and decode helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [1:0]  lo;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // funct3[1:0] encodes access size for both loads and stores
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return {lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic: load extract/extend and sub-word store merge into an old word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        shifted = word >> {lo, 3'b000};
        rdata   = '0;
        case (funct3)
            F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata = word;
            F3_LBU:  rdata = {24'b0, shifted[7:0]};
            F3_LHU:  rdata = {16'b0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        mask   = '0;
        merged = wdata;
        case (funct3[1:0])
            2'b00: begin
                mask   = 32'h0000_00FF << {lo, 3'b000};
                merged = (word & ~mask) | ({24'b0, wdata[7:0]} << {lo, 3'b000});
            end
            2'b01: begin
                mask   = 32'h0000_FFFF << {lo[1], 4'b0000};
                merged = (word & ~mask) | ({16'b0, wdata[15:0]} << {lo[1], 4'b0000});
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a word-wide memory; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int MEM_SIZE  = 1024,
    localparam int ADDR_BITS = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_error,
    output logic                 mem_write_enable,
    output logic                 mem_read_enable,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic [31:0]          mem_input_data,
    input  logic [31:0]          mem_output_data
);

    lsu_state_t  state;
    lsu_req_t    req_q;
    logic        acc_err;
    logic [1:0]  acc_lo;
    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_err = !f3_legal(req_write, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
    assign acc_lo  = req_addr[1:0];
`else
    assign acc_err = !f3_legal(req_write, req_funct3);
    assign acc_lo  = align_lo(req_funct3, req_addr[1:0]);
`endif

    lsu_align u_align (
        .word   (mem_output_data),
        .funct3 (req_q.funct3),
        .lo     (req_q.lo),
        .wdata  (req_q.wdata),
        .rdata  (ld_data),
        .merged (st_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            req_q            <= '0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_error       <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_address      <= '0;
            mem_input_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        req_q     <= '{write: req_write, funct3: req_funct3,
                                       lo: acc_lo, wdata: req_wdata};
                        if (acc_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && (req_funct3[1:0] == 2'b10)) begin
                            // full-word store needs no old data
                            state            <= WRITE;
                            mem_address      <= req_addr[ADDR_BITS+1:2];
                            mem_write_enable <= 1'b1;
                            mem_input_data   <= req_wdata;
                        end else begin
                            state           <= READ;
                            mem_address     <= req_addr[ADDR_BITS+1:2];
                            mem_read_enable <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_read_enable <= 1'b0;
                    if (req_q.write) begin
                        state            <= WRITE;
                        mem_write_enable <= 1'b1;
                        mem_input_data   <= st_word;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= ld_data;
                    end
                end
                WRITE: begin
                    mem_write_enable <= 1'b0;
                    state            <= RESP;
                    resp_valid       <= 1'b1;
                    resp_error       <= 1'b0;
                    resp_rdata       <= '0;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    localparam int MEM_SIZE = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [9:0]  mem_address;
    logic [31:0] mem_input_data;
    logic [31:0] mem_output_data;

    logic [31:0] mem [0:MEM_SIZE-1];

    int total = 0;
    int bad   = 0;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_address      (mem_address),
        .mem_input_data   (mem_input_data),
        .mem_output_data  (mem_output_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write_enable) mem[mem_address] <= mem_input_data;
    assign mem_output_data = mem_read_enable ? mem[mem_address] : 32'h0BAD_0BAD;

    always @(negedge clk) begin
        if (mem_read_enable && mem_write_enable) begin
            total++; bad++;
            $display("FAIL enables_exclusive: both enables high at %0t", $time);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Issue one request and follow it to its response (latency counted from the accept edge).
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output logic saw_re, output logic saw_we,
                          output logic [9:0] we_addr, output logic [31:0] we_data);
        int n;
        lat = 99; rd = '0; er = 1'b0; saw_re = 1'b0; saw_we = 1'b0; we_addr = '0; we_data = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (mem_read_enable) saw_re = 1'b1;
            if (mem_write_enable) begin saw_we = 1'b1; we_addr = mem_address; we_data = mem_input_data; end
            if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_error; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        total++; if (resp_rdata !== 32'h0 || resp_error !== 1'b0) begin bad++; $display("FAIL reset_resp: got %h/%b want 0/0", resp_rdata, resp_error); end
        total++; if (mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin bad++; $display("FAIL reset_enables: got we=%b re=%b want 0/0", mem_write_enable, mem_read_enable); end
        total++; if (mem_address !== 10'h0 || mem_input_data !== 32'h0) begin bad++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_address, mem_input_data); end
    endtask

    task automatic test_sw_lw();
        int lat; logic [31:0] rd; logic er, sre, swe; logic [9:0] wa; logic [31:0] wd;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, sre, swe, wa, wd);
        total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
        total++; if (swe !== 1'b1 || wa !== 10'd4) begin bad++; $display("FAIL sw_write_addr: got we=%b addr=%0d want 1/4", swe, wa); end
        total++; if (wd !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_write_data: got %h want deadbeef", wd); end
        total++; if (sre !== 1'b0) begin bad++; $display("FAIL sw_no_read: got %b want 0", sre); end
        total++; if (mem[4] !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL sw_mem: got %h err=%b want deadbeef/0", mem[4], er); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (lat !== 2 || sre !== 1'b1 || swe !== 1'b0) begin bad++; $display("FAIL lw_timing: got lat=%0d re=%b we=%b want 2/1/0", lat, sre, swe); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_sub_store();
        int lat; logic [31:0] rd; logic er, sre, swe; logic [9:0] wa; logic [31:0] wd;
        do_req(1'b1, 3'b000, 32'h12, 32'hFFFF_FFA5, lat, rd, er, sre, swe, wa, wd);
        total++; if (lat !== 3) begin bad++; $display("FAIL sb_latency: got %0d want 3", lat); end
        total++; if (sre !== 1'b1 || swe !== 1'b1 || wa !== 10'd4) begin bad++; $display("FAIL sb_rmw: got re=%b we=%b addr=%0d want 1/1/4", sre, swe, wa); end
        total++; if (wd !== 32'hDEA5BEEF) begin bad++; $display("FAIL sb_merge: got %h want dea5beef", wd); end
        total++; if (mem[4] !== 32'hDEA5BEEF || rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL sb_mem: got %h rd=%h err=%b want dea5beef/0/0", mem[4], rd, er); end
    endtask

    task automatic test_loads();
        int lat; logic [31:0] rd; logic er, sre, swe; logic [9:0] wa; logic [31:0] wd;
        do_req(1'b0, 3'b000, 32'h12, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (rd !== 32'hFFFFFFA5 || lat !== 2) begin bad++; $display("FAIL lb: got %h lat=%0d want ffffffa5/2", rd, lat); end
        do_req(1'b0, 3'b100, 32'h12, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (rd !== 32'h000000A5) begin bad++; $display("FAIL lbu: got %h want 000000a5", rd); end
        do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (rd !== 32'hFFFFDEA5) begin bad++; $display("FAIL lh: got %h want ffffdea5", rd); end
        do_req(1'b0, 3'b101, 32'h10, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL lhu: got %h want 0000beef", rd); end
        do_req(1'b0, 3'b000, 32'h11, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (rd !== 32'hFFFFFFBE) begin bad++; $display("FAIL lb_lane1: got %h want ffffffbe", rd); end
        do_req(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (rd !== 32'h000000DE) begin bad++; $display("FAIL lbu_lane3: got %h want 000000de", rd); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic er, sre, swe; logic [9:0] wa; logic [31:0] wd;
        do_req(1'b0, 3'b010, 32'h11, 32'h0, lat, rd, er, sre, swe, wa, wd);
`ifdef LSU_MISALIGN_TRAP_EN
        total++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin bad++; $display("FAIL lw_misalign: got err=%b rd=%h lat=%0d want 1/0/1", er, rd, lat); end
        total++; if (sre !== 1'b0 || swe !== 1'b0) begin bad++; $display("FAIL lw_misalign_noacc: got re=%b we=%b want 0/0", sre, swe); end
`else
        total++; if (er !== 1'b0 || rd !== 32'hDEA5BEEF || lat !== 2) begin bad++; $display("FAIL lw_misalign: got err=%b rd=%h lat=%0d want 0/dea5beef/2", er, rd, lat); end
        do_req(1'b0, 3'b001, 32'h13, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (er !== 1'b0 || rd !== 32'hFFFFDEA5) begin bad++; $display("FAIL lh_misalign: got err=%b rd=%h want 0/ffffdea5", er, rd); end
`endif
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er, sre, swe; logic [9:0] wa; logic [31:0] wd;
        logic saw_we;
        do_req(1'b1, 3'b010, 32'h20, 32'h12345678, lat, rd, er, sre, swe, wa, wd);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = 32'hFFFFBEEF;
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (mem_read_enable !== 1'b1) begin bad++; $display("FAIL sh_in_read: got re=%b want 1", mem_read_enable); end
        rst = 1'b1; #1;
        total++; if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin bad++; $display("FAIL rst_mid_enables: got re=%b we=%b want 0/0", mem_read_enable, mem_write_enable); end
        saw_we = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (mem_write_enable) saw_we = 1'b1; end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (mem_write_enable) saw_we = 1'b1; end
        total++; if (saw_we !== 1'b0 || mem[8] !== 32'h12345678) begin bad++; $display("FAIL rst_mid_mem: got we=%b word8=%h want 0/12345678", saw_we, mem[8]); end
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_ready: got rdy=%b rv=%b want 1/0", req_ready, resp_valid); end
        do_req(1'b1, 3'b001, 32'h22, 32'hFFFFBEEF, lat, rd, er, sre, swe, wa, wd);
        total++; if (lat !== 3 || mem[8] !== 32'hBEEF5678) begin bad++; $display("FAIL sh_after_rst: got lat=%0d word8=%h want 3/beef5678", lat, mem[8]); end
    endtask

    task automatic test_error_wrap();
        int lat; logic [31:0] rd; logic er, sre, swe; logic [9:0] wa; logic [31:0] wd;
        do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin bad++; $display("FAIL f3_011: got err=%b rd=%h lat=%0d want 1/0/1", er, rd, lat); end
        total++; if (sre !== 1'b0 || swe !== 1'b0) begin bad++; $display("FAIL f3_011_noacc: got re=%b we=%b want 0/0", sre, swe); end
        repeat (2) @(posedge clk); #1;
        total++; if (resp_error !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL err_hold: got err=%b rv=%b want 1/0", resp_error, resp_valid); end
        do_req(1'b1, 3'b100, 32'h10, 32'h55, lat, rd, er, sre, swe, wa, wd);
        total++; if (er !== 1'b1 || swe !== 1'b0 || mem[4] !== 32'hDEA5BEEF) begin bad++; $display("FAIL store_f3_100: got err=%b we=%b word4=%h want 1/0/dea5beef", er, swe, mem[4]); end
        do_req(1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, lat, rd, er, sre, swe, wa, wd);
        total++; if (wa !== 10'd0 || mem[0] !== 32'hCAFEF00D || er !== 1'b0) begin bad++; $display("FAIL wrap: got addr=%0d word0=%h err=%b want 0/cafef00d/0", wa, mem[0], er); end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, er, sre, swe, wa, wd);
        total++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin bad++; $display("FAIL wrap_read: got %h err=%b want cafef00d/0", rd, er); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_sub_store();
        test_loads();
        test_misalign();
        test_reset_mid();
        test_error_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
